// File: rtl/pwd_cand_pkg.sv
// Shared definitions for the password candidate generator and the md5 top level.
// Provides the candidate width, digit count and start-value sanitiser.
package pwd_cand_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam int         CAND_W     = 64;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CAND_W-1:0] CAND_ZERO = {NUM_DIGITS{ASCII_ZERO}};

  // Any byte that is not an ASCII decimal digit becomes '0'.
  function automatic logic [CAND_W-1:0] sanitize(input logic [CAND_W-1:0] v);
    logic [CAND_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[8*i +: 8] < 8'h30 || v[8*i +: 8] > 8'h39)
        r[8*i +: 8] = ASCII_ZERO;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwd_cand_gen_if.sv
// Candidate valid/ready stream between the generator (master) and an md5 core (slave).
interface pwd_cand_gen_if;
  import pwd_cand_pkg::*;

  logic [CAND_W-1:0] cand;
  logic              cand_valid;
  logic              cand_ready;

  modport master (output cand, output cand_valid, input cand_ready);
  modport slave  (input cand, input cand_valid, output cand_ready);

endinterface

// File: rtl/pwd_cand_gen_bcd_digit_add.sv
// One BCD digit of the ripple-carry candidate adder.
module bcd_digit_add (
  input  logic [3:0] digit_in,
  input  logic [3:0] addend,
  input  logic       carry_in,
  output logic [3:0] digit_out,
  output logic       carry_out
);

  logic [4:0] raw;

  // Operands are at most 9 + 9 + 1, so a single -10 correction suffices.
  always_comb begin
    raw = {1'b0, digit_in} + {1'b0, addend} + {4'b0, carry_in};
    if (raw > 5'd9) begin
      digit_out = 4'(raw - 5'd10);
      carry_out = 1'b1;
    end else begin
      digit_out = raw[3:0];
      carry_out = 1'b0;
    end
  end

endmodule

// File: rtl/pwd_cand_gen.sv
// Decimal ASCII password candidate generator: start_val, start_val+STRIDE, ... up to 99999999.
// Optional `PWD_CAND_GEN_COUNT_EN adds the issued_cnt handshake counter output.
module pwd_cand_gen
  import pwd_cand_pkg::*;
#(
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CAND_W-1:0] start_val,
  input  logic              stop,
  pwd_cand_gen_if.master    cand_if,
  output logic              busy,
`ifdef PWD_CAND_GEN_COUNT_EN
  output logic [26:0]       issued_cnt,
`endif
  output logic              done
);

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] RUN  = 2'(ST_RUN);
  localparam logic [1:0] DONE = 2'(ST_DONE);
  localparam logic [3:0] STEP = 4'(STRIDE);

  logic [1:0]                      state;
  logic [CAND_W-1:0]               cand_q;
  logic                            busy_q;
  logic                            done_q;
  logic [NUM_DIGITS-1:0][3:0]      sum_dig;
  logic [NUM_DIGITS:0]             carry;
  logic [CAND_W-1:0]               cand_nxt;
  logic                            ovf;
  logic                            hs;
  logic                            start_acc;

  assign carry[0] = 1'b0;

  // STRIDE enters at the least significant digit; the rest only propagate carry.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_add u_dig (
      .digit_in  (cand_q[8*i +: 4]),
      .addend    ((i == 0) ? STEP : 4'd0),
      .carry_in  (carry[i]),
      .digit_out (sum_dig[i]),
      .carry_out (carry[i+1])
    );
    assign cand_nxt[8*i +: 8] = {4'h3, sum_dig[i]};
  end

  assign ovf       = carry[NUM_DIGITS];
  assign hs        = busy_q & cand_if.cand_ready;
  assign start_acc = (state == IDLE) & start & ~stop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cand_q <= CAND_ZERO;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start_acc) begin
          state  <= RUN;
          busy_q <= 1'b1;
          cand_q <= sanitize(start_val);
        end
        RUN: begin
          // The last candidate stays on cand; there is no wrap past 99999999.
          if (hs && !ovf) cand_q <= cand_nxt;
          if (stop) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (hs && ovf) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PWD_CAND_GEN_COUNT_EN
  logic [26:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       cnt_q <= '0;
    else if (start_acc) cnt_q <= '0;
    else if (hs)        cnt_q <= cnt_q + 27'd1;
  end

  assign issued_cnt = cnt_q;
`endif

  assign cand_if.cand       = cand_q;
  assign cand_if.cand_valid = busy_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_pwd_cand_gen.sv
// Directed bench for pwd_cand_gen: one instance with STRIDE=1 and one with STRIDE=4.
module tb_pwd_cand_gen;
  import pwd_cand_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start1 = 1'b0, stop1 = 1'b0, busy1, done1;
  logic              start4 = 1'b0, stop4 = 1'b0, busy4, done4;
  logic [CAND_W-1:0] sv1 = '0, sv4 = '0;
  int                errs = 0;
  int                checks = 0;
`ifdef PWD_CAND_GEN_COUNT_EN
  logic [26:0]       cnt1, cnt4;
`endif

  pwd_cand_gen_if if1 ();
  pwd_cand_gen_if if4 ();

  always #5 clk = ~clk;

  pwd_cand_gen #(.STRIDE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .start_val(sv1), .stop(stop1),
    .cand_if(if1), .busy(busy1),
`ifdef PWD_CAND_GEN_COUNT_EN
    .issued_cnt(cnt1),
`endif
    .done(done1));

  pwd_cand_gen #(.STRIDE(4)) u4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .start_val(sv4), .stop(stop4),
    .cand_if(if4), .busy(busy4),
`ifdef PWD_CAND_GEN_COUNT_EN
    .issued_cnt(cnt4),
`endif
    .done(done4));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] s;
    if1.cand_ready = 1'b0;
    if4.cand_ready = 1'b0;
    #12;
    chk("rst_cand", if1.cand, "00000000");
    chk("rst_valid", 64'(if1.cand_valid), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // streaming with ready held high
    sv1 = "00000008"; start1 = 1'b1; if1.cand_ready = 1'b1;
    tick(); start1 = 1'b0;
    chk("seq0", if1.cand, "00000008");
    chk("seq_busy", 64'(busy1), 64'd1);
    chk("seq_valid", 64'(if1.cand_valid), 64'd1);
    tick(); chk("seq1", if1.cand, "00000009");
    tick(); chk("seq2", if1.cand, "00000010");
    tick(); chk("seq3", if1.cand, "00000011");
    if1.cand_ready = 1'b0; stop1 = 1'b1;
    tick(); stop1 = 1'b0;
    chk("stop_valid", 64'(if1.cand_valid), 64'd0);
    chk("stop_hold", if1.cand, "00000011");

    // backpressure: ready low for three cycles
    sv1 = "00000008"; start1 = 1'b1;
    tick(); start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", if1.cand, "00000008");
      tick();
    end
    chk("bp_hold4", if1.cand, "00000008");
    if1.cand_ready = 1'b1;
    tick(); chk("bp_next", if1.cand, "00000009");
    if1.cand_ready = 1'b0; stop1 = 1'b1;
    tick(); stop1 = 1'b0;

    // stop together with a handshake; start while busy ignored
    sv1 = "00001234"; start1 = 1'b1; if1.cand_ready = 1'b1;
    tick(); start1 = 1'b0;
    chk("st0", if1.cand, "00001234");
    tick(); chk("st1", if1.cand, "00001235");
    sv1 = "55555555"; start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk("st_restart_ign", if1.cand, "00001236");
    chk("st_busy", 64'(busy1), 64'd1);
    tick(); chk("st3", if1.cand, "00001237");
    stop1 = 1'b1;
    tick(); stop1 = 1'b0;
    chk("st_cand", if1.cand, "00001238");
    chk("st_valid", 64'(if1.cand_valid), 64'd0);
    chk("st_busy0", 64'(busy1), 64'd0);
    chk("st_nodone", 64'(done1), 64'd0);
    tick();
    chk("st_nodone2", 64'(done1), 64'd0);
    chk("st_hold2", if1.cand, "00001238");

    // exhaustion with STRIDE=4
    sv4 = "99999991"; start4 = 1'b1; if4.cand_ready = 1'b1;
    tick(); start4 = 1'b0;
    chk("ex0", if4.cand, "99999991");
    tick(); chk("ex1", if4.cand, "99999995");
    tick(); chk("ex2", if4.cand, "99999999");
    chk("ex2_done", 64'(done4), 64'd0);
    tick();
    chk("ex_done", 64'(done4), 64'd1);
    chk("ex_valid", 64'(if4.cand_valid), 64'd0);
    chk("ex_busy", 64'(busy4), 64'd0);
    chk("ex_hold", if4.cand, "99999999");
    sv4 = "00000001"; start4 = 1'b1;
    tick(); start4 = 1'b0;
    chk("ex_done_1cyc", 64'(done4), 64'd0);
    chk("ex_start_in_done", 64'(busy4), 64'd0);
    chk("ex_hold2", if4.cand, "99999999");

    // single-candidate run at the top of the key space
    sv1 = "99999999"; start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk("top_cand", if1.cand, "99999999");
    chk("top_valid", 64'(if1.cand_valid), 64'd1);
    tick();
    chk("top_done", 64'(done1), 64'd1);
    chk("top_hold", if1.cand, "99999999");
    tick();

    // start and stop together: stop wins
    sv1 = "00000042"; start1 = 1'b1; stop1 = 1'b1;
    tick(); start1 = 1'b0; stop1 = 1'b0;
    chk("ss_busy", 64'(busy1), 64'd0);
    chk("ss_cand", if1.cand, "99999999");

    // sanitising, then asynchronous reset between edges
    if1.cand_ready = 1'b0;
    sv1 = "12A45B78"; start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk("san", if1.cand, "12045078");
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(if1.cand_valid), 64'd0);
    chk("ar_busy", 64'(busy1), 64'd0);
    chk("ar_done", 64'(done1), 64'd0);
    chk("ar_cand", if1.cand, "00000000");
    tick(); reset_n = 1'b1;
    tick();

`ifdef PWD_CAND_GEN_COUNT_EN
    sv1 = "00000000"; start1 = 1'b1; if1.cand_ready = 1'b1;
    tick(); start1 = 1'b0;
    chk("cnt0", 64'(cnt1), 64'd0);
    for (int i = 0; i < 25; i++) tick();
    if1.cand_ready = 1'b0; stop1 = 1'b1;
    chk("cnt25", 64'(cnt1), 64'd25);
    s = "00000025";
    chk("cnt_cand", if1.cand, s);
    tick(); stop1 = 1'b0;
    chk("cnt_idle_hold", 64'(cnt1), 64'd25);
    sv1 = "00000100"; start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk("cnt_clr", 64'(cnt1), 64'd0);
    stop1 = 1'b1;
    tick(); stop1 = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pwd_cand_gen.md
# pwd_cand_gen

Upstream candidate source for the MD5 password-cracking datapath. Produces 8-character ASCII decimal password candidates ("00000000".."99999999") on a valid/ready stream consumed by an md5 core. Each candidate is the previous one plus STRIDE, in decimal. Several instances with different start values and a shared STRIDE partition the key space across parallel md5 engines. The top-level FSM starts the block, stops it on a hash match, and times the search.

## Interface
Parameters:
- STRIDE, default 1: decimal increment between successive candidates. Legal range is 1..9; it equals the number of parallel engines.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; latches start_val and begins a run
- start_val  in  64  first candidate as 8 ASCII digits; byte [63:56] is the most significant digit
- stop  in  1  single-cycle pulse; aborts a run (match found elsewhere)
- cand  out  64  current candidate in ASCII, same byte order as start_val
- cand_valid  out  1  cand holds a valid candidate
- cand_ready  in  1  consumer accepts cand when high together with cand_valid
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when the key space is exhausted

## Operation
- States:
  - IDLE: reset state.
  - RUN
  - DONE: lasts one cycle.
- IDLE → RUN on start, unless stop is also high (stop wins; stay in IDLE).
  - On entering RUN, cand is loaded from start_val.
  - Any start_val byte outside 8'h30..8'h39 is replaced by 8'h30.
- In RUN:
  - cand_valid = 1.
  - On handshake (cand_valid & cand_ready), cand advances by STRIDE.
  - The add is BCD on the low nibbles with ripple carry over 8 digits; the high nibble of every byte stays 4'h3.
- Last candidate: if the handshaken cand plus STRIDE would exceed 99999999, there is no wrap. The block goes to DONE, cand_valid falls, and cand holds the last value.
- DONE → IDLE unconditionally; done = 1 for exactly that cycle.
- stop in RUN: the block goes to IDLE next cycle with no done pulse, and cand holds its value.
  - If stop coincides with a handshake, the transfer still counts (cand advances), then the block goes IDLE.
- start while busy or in DONE is ignored.
- stop in IDLE or DONE is ignored.
- Asynchronous reset at any time forces IDLE with all outputs at their reset values.

## Timing
- Reset values:
  - cand = 64'h3030303030303030 ("00000000")
  - cand_valid = 0, busy = 0, done = 0
- start sampled at edge t: cand_valid = 1 and cand = start_val (sanitised) after edge t, i.e. visible in cycle t+1.
- Throughput: one candidate per cycle while cand_ready is held high.
- Backpressure: while cand_valid & !cand_ready, cand is stable, with no skips and no duplicates.
- All outputs are registered; there is no combinational path from cand_ready to cand or cand_valid.
- busy equals (state == RUN).
- done is registered and asserts the cycle after the final handshake.

## Configuration
- PWD_CAND_GEN_COUNT_EN defined:
  - Adds output issued_cnt, 27 bits (max 10^8 − 1 fits).
  - Cleared to 0 on reset and on accepted start; incremented by 1 per handshake; holds its value in IDLE and DONE.
- Undefined: the issued_cnt port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package pwd_cand_pkg:
  - State enum (IDLE, RUN, DONE)
  - NUM_DIGITS = 8, CAND_W = 64, ASCII_ZERO = 8'h30
  - Shared with the md5 top level for the candidate width.
- Sub-module bcd_digit_add:
  - Inputs: 4-bit digit, 4-bit addend, carry-in. Outputs: 4-bit digit, carry-out.
  - Instantiated 8× in a ripple chain; STRIDE is applied at digit 0, addend 0 elsewhere.
  - Carry-out of digit 7 is the "would exceed" flag.

## Test plan
- STRIDE=1, start_val "00000008", cand_ready held 1:
  - cand sequence "00000008", "00000009", "00000010", "00000011" on consecutive cycles; busy = 1.
- Backpressure: cand_ready low for 3 cycles after the first candidate:
  - cand stays "00000008" for 4 cycles, then "00000009"; no skip.
- Exhaustion, STRIDE=4, start_val "99999991":
  - cand "99999991", "99999995", "99999999".
  - done pulse 1 cycle after the last handshake; cand_valid = 0; cand holds "99999999"; state returns to IDLE.
- Stop: STRIDE=1 from "00001234":
  - stop pulsed together with the handshake of "00001237" → next cycle cand_valid = 0, cand = "00001238", no done.
  - A second start while busy is ignored.
- Sanitising and reset: start_val "12A45B78" → first cand "12045078".
  - reset_n dropped mid-run between clock edges → cand_valid, busy, done = 0 immediately and cand = "00000000".
- With PWD_CAND_GEN_COUNT_EN defined, STRIDE=1 from "00000000", 25 handshakes → issued_cnt = 25.
  - A new start clears issued_cnt to 0.
